pc_fetch_unit: RTL and testbench

- Sequential instruction-fetch front end. Owns the architectural PC register and drives a single-outstanding req/ack instruction-memory port.
- Presents fetched instructions to decode over a valid/ready handshake.
- Consumes the PC+4 increment and the branch/jump redirects from execute. It is the register and control side of the next-PC path.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/pc_inc.sv | 13 +
 rtl/pc_fetch_unit.sv | 140 ++++++++++++++
 tb/tb_pc_fetch_unit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_VEC_DEF = 32'h0000_0000;
  localparam int PC_STEP_DEF = 4;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    VALID  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  // Instructions are word aligned; the low two address bits are dropped.
  function automatic logic [XLEN-1:0] align_target(input logic [XLEN-1:0] target);
    return {target[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_inc.sv
// Sequential next-PC adder; the carry out of the top bit is discarded so the PC wraps.
module pc_inc
  import cpu_pkg::*;
#(
  parameter int PC_STEP = PC_STEP_DEF
) (
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_next
);

  assign pc_next = pc + XLEN'(PC_STEP);

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end: PC register, single-outstanding imem port,
// valid/ready delivery to decode and branch/jump redirect handling.
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = RESET_VEC_DEF,
  parameter int          PC_STEP   = PC_STEP_DEF
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        halt,
  output logic        halted,
  output logic        misalign
);

  fetch_state_t state, state_nx;
  logic [31:0]  pc, pc_nx, pc_seq;
  logic         redirect_pending, redirect_pending_nx;
  logic [31:0]  pending_target, pending_target_nx;
  logic         halt_latched, halt_latched_nx;
  logic         req_nx, valid_nx, halted_nx, misalign_nx;
  logic         load_instr;
  logic         redirect_now, handshake, halt_any;
  logic [31:0]  raw_target, target;

  pc_inc #(.PC_STEP(PC_STEP)) u_pc_inc (
    .pc      (pc),
    .pc_next (pc_seq)
  );

  assign imem_addr    = pc;
  assign redirect_now = branch_taken | jump;
  assign raw_target   = branch_taken ? branch_target : jump_target;
  assign target       = align_target(raw_target);
  assign handshake    = instr_valid & instr_ready;
  assign halt_any     = halt_latched | halt;

  always_comb begin
    state_nx            = state;
    pc_nx               = pc;
    redirect_pending_nx = redirect_pending;
    pending_target_nx   = pending_target;
    halt_latched_nx     = halt_latched | halt;
    load_instr          = 1'b0;
    misalign_nx         = 1'b0;

    case (state)
      FETCH: begin
        misalign_nx = redirect_now & (|raw_target[1:0]);
        if (!imem_req) begin
          // No request is outstanding yet, so a redirect can retarget directly.
          if (redirect_now) pc_nx = target;
        end else if (imem_ack) begin
          if (redirect_now) begin
            pc_nx               = target;
            redirect_pending_nx = 1'b0;
          end else if (redirect_pending) begin
            pc_nx               = pending_target;
            redirect_pending_nx = 1'b0;
          end else begin
            load_instr = 1'b1;
            pc_nx      = pc_seq;
            state_nx   = VALID;
          end
        end else if (redirect_now) begin
          // The request stays up; its data is discarded when the ack arrives.
          redirect_pending_nx = 1'b1;
          pending_target_nx   = target;
        end
      end

      VALID: begin
        if (handshake && halt_any) begin
          state_nx = HALTED;
        end else if (redirect_now) begin
          pc_nx       = target;
          state_nx    = FETCH;
          misalign_nx = |raw_target[1:0];
        end else if (handshake) begin
          state_nx = FETCH;
        end
      end

      HALTED: begin
        state_nx = HALTED;
      end

      default: begin
        state_nx = FETCH;
      end
    endcase

    req_nx    = (state_nx == FETCH);
    valid_nx  = (state_nx == VALID);
    halted_nx = (state_nx == HALTED);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= FETCH;
      pc               <= RESET_VEC;
      imem_req         <= 1'b0;
      instr_out        <= 32'h0;
      instr_pc         <= 32'h0;
      instr_valid      <= 1'b0;
      halted           <= 1'b0;
      misalign         <= 1'b0;
      redirect_pending <= 1'b0;
      pending_target   <= 32'h0;
      halt_latched     <= 1'b0;
    end else begin
      state            <= state_nx;
      pc               <= pc_nx;
      imem_req         <= req_nx;
      instr_valid      <= valid_nx;
      halted           <= halted_nx;
      misalign         <= misalign_nx;
      redirect_pending <= redirect_pending_nx;
      pending_target   <= pending_target_nx;
      halt_latched     <= halt_latched_nx;
      if (load_instr) begin
        instr_out <= imem_rdata;
        instr_pc  <= pc;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: transaction-level driver with randomized
// memory latency, decode stalls and redirects; a negedge monitor checks delivery.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        halt;
  logic        halted;
  logic        misalign;

  localparam int M_NONE  = 0;
  localparam int M_EARLY = 1;
  localparam int M_SAME  = 2;
  localparam int M_NOHS  = 3;
  localparam int M_HS    = 4;

  int          total  = 0;
  int          passed = 0;
  logic [63:0] exp_q[$];
  logic [31:0] exp_addr;

  pc_fetch_unit #(.RESET_VEC(32'h0000_0000), .PC_STEP(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr_out     (instr_out),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .halt          (halt),
    .halted        (halted),
    .misalign      (misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return {addr[15:0], addr[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic finish_run();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  endtask

  // Advance one clock; misalign must reflect the redirect offered in that cycle.
  task automatic step(input bit eff);
    logic        mis_exp;
    logic [31:0] raw;
    raw     = branch_taken ? branch_target : jump_target;
    mis_exp = eff && (branch_taken || jump) && (raw[1:0] != 2'b00);
    @(posedge clk);
    #1;
    check("misalign", 32'(misalign), 32'(mis_exp));
    branch_taken = 1'b0;
    jump         = 1'b0;
    imem_ack     = 1'b0;
    instr_ready  = 1'b0;
    halt         = 1'b0;
  endtask

  // sel: 0 branch only, 1 jump only, 2 both (branch wins).
  task automatic set_redirect(input int sel, input logic [31:0] bt, input logic [31:0] jt,
                              output logic [31:0] tgt);
    branch_taken  = (sel != 1);
    jump          = (sel != 0);
    branch_target = bt;
    jump_target   = jt;
    tgt = ((sel != 1) ? bt : jt) & 32'hFFFF_FFFC;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imem_req) begin
      if (n == 4) begin
        check("req_timeout", 32'(imem_req), 32'd1);
        finish_run();
      end
      step(1'b1);
      n++;
    end
  endtask

  task automatic do_txn(input int mode, input int d, input int s, input int sel,
                        input logic [31:0] bt, input logic [31:0] jt);
    logic [31:0] tgt;
    tgt = 32'h0;
    wait_req();
    check("fetch_addr", imem_addr, exp_addr);
    for (int i = 0; i < d; i++) begin
      if (mode == M_EARLY && i == 0) set_redirect(sel, bt, jt, tgt);
      step(1'b1);
      check("req_hold", 32'(imem_req), 32'd1);
      check("addr_hold", imem_addr, exp_addr);
      check("valid_wait", 32'(instr_valid), 32'd0);
    end
    imem_ack   = 1'b1;
    imem_rdata = mem_word(exp_addr);
    if (mode == M_SAME) set_redirect(sel, bt, jt, tgt);
    step(1'b1);
    imem_rdata = $urandom;
    if (mode == M_EARLY || mode == M_SAME) begin
      check("discard_valid", 32'(instr_valid), 32'd0);
      check("discard_req", 32'(imem_req), 32'd1);
      check("redirect_addr", imem_addr, tgt);
      exp_addr = tgt;
      return;
    end
    exp_q.push_back({exp_addr, mem_word(exp_addr)});
    check("deliver_valid", 32'(instr_valid), 32'd1);
    check("deliver_req", 32'(imem_req), 32'd0);
    exp_addr = exp_addr + 32'd4;
    for (int i = 0; i < s; i++) begin
      step(1'b1);
      check("stall_valid", 32'(instr_valid), 32'd1);
    end
    if (mode == M_NOHS) begin
      set_redirect(sel, bt, jt, tgt);
      step(1'b1);
      void'(exp_q.pop_back());
      exp_addr = tgt;
    end else if (mode == M_HS) begin
      set_redirect(sel, bt, jt, tgt);
      instr_ready = 1'b1;
      step(1'b1);
      exp_addr = tgt;
    end else begin
      instr_ready = 1'b1;
      step(1'b1);
    end
    check("post_valid", 32'(instr_valid), 32'd0);
    check("post_req", 32'(imem_req), 32'd1);
    check("next_addr", imem_addr, exp_addr);
  endtask

  task automatic halt_test();
    logic [31:0] tgt;
    wait_req();
    check("halt_fetch_addr", imem_addr, exp_addr);
    halt = 1'b1;
    step(1'b1);
    check("halt_req_kept", 32'(imem_req), 32'd1);
    imem_ack   = 1'b1;
    imem_rdata = mem_word(exp_addr);
    step(1'b1);
    exp_q.push_back({exp_addr, mem_word(exp_addr)});
    exp_addr = exp_addr + 32'd4;
    check("halt_deliver", 32'(instr_valid), 32'd1);
    check("halted_early", 32'(halted), 32'd0);
    step(1'b1);
    instr_ready = 1'b1;
    step(1'b1);
    check("halted", 32'(halted), 32'd1);
    check("halted_req", 32'(imem_req), 32'd0);
    check("halted_valid", 32'(instr_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      if (i == 0) set_redirect(1, 32'h0, 32'h0000_0303, tgt);
      step(1'b0);
      check("halted_stays", 32'(halted), 32'd1);
      check("halted_pc_frozen", imem_addr, exp_addr);
      check("halted_req_low", 32'(imem_req), 32'd0);
    end
    reset = 1'b1;
    #2;
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    exp_addr = 32'h0;
  endtask

  // Monitor: a valid instruction must match the scoreboard head; a handshake retires it.
  always @(negedge clk) begin
    if (!reset && instr_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_valid: got instr_pc %h with nothing expected", instr_pc);
      end else begin
        check("instr_pc", instr_pc, exp_q[0][63:32]);
        check("instr_out", instr_out, exp_q[0][31:0]);
        if (instr_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    finish_run();
  end

  initial begin
    int mode, d, s, sel;
    logic [31:0] bt, jt;
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
    branch_taken = 1'b0; branch_target = 32'h0; jump = 1'b0; jump_target = 32'h0;
    halt = 1'b0; exp_addr = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_req", 32'(imem_req), 32'd0);
    check("reset_addr", imem_addr, 32'h0);
    check("reset_valid", 32'(instr_valid), 32'd0);
    check("reset_instr_out", instr_out, 32'h0);
    check("reset_halted", 32'(halted), 32'd0);
    check("reset_misalign", 32'(misalign), 32'd0);
    reset = 1'b0;
    step(1'b1);
    check("first_req", 32'(imem_req), 32'd1);

    do_txn(M_NONE, 0, 0, 0, 32'h0, 32'h0);
    do_txn(M_NONE, 3, 4, 0, 32'h0, 32'h0);
    do_txn(M_NONE, 0, 0, 0, 32'h0, 32'h0);
    do_txn(M_EARLY, 2, 0, 0, 32'h0000_0100, 32'h0);
    do_txn(M_NOHS, 0, 1, 2, 32'h0000_0200, 32'h0000_0300);
    do_txn(M_HS, 0, 0, 1, 32'h0, 32'h0000_0302);
    do_txn(M_HS, 1, 0, 0, 32'hFFFF_FFFC, 32'h0);
    do_txn(M_NONE, 0, 0, 0, 32'h0, 32'h0);
    do_txn(M_NONE, 0, 0, 0, 32'h0, 32'h0);

    for (int k = 0; k < 60; k++) begin
      mode = int'($urandom_range(0, 4));
      d    = int'($urandom_range(0, 3));
      if (mode == M_EARLY && d == 0) d = 1;
      s    = int'($urandom_range(0, 3));
      sel  = int'($urandom_range(0, 2));
      bt   = $urandom;
      jt   = $urandom;
      if ($urandom_range(0, 3) == 0) bt = 32'($urandom_range(0, 255));
      do_txn(mode, d, s, sel, bt, jt);
    end

    halt_test();
    do_txn(M_NONE, 0, 0, 0, 32'h0, 32'h0);
    do_txn(M_SAME, 1, 0, 1, 32'h0, 32'h0000_0041);
    do_txn(M_NONE, 0, 2, 0, 32'h0, 32'h0);

    step(1'b1);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    finish_run();
  end

endmodule
